// File: rtl/meikyuu_pkg.sv
// Shared constants and FSM state type for the maze player movement logic.
// Bounds are in VGA counter coordinates for the default 16-pixel sprite.
package meikyuu_pkg;

  localparam int SPRITE_DEF = 16;
  localparam int X_MIN      = 97;
  localparam int X_MAX      = 736 - SPRITE_DEF;
  localparam int Y_MIN      = 3;
  localparam int Y_MAX      = 482 - SPRITE_DEF;

  localparam logic [9:0] X_RST    = 10'd408;
  localparam logic [9:0] Y_RST    = 10'd234;
  localparam logic [1:0] ROOM_RST = 2'd1;

  localparam int GRID_W = 3;
  localparam int GRID_H = 3;

  // Last QUERY cycle index before an unanswered query is abandoned (255 cycles)
  localparam logic [7:0] QUERY_LAST = 8'd254;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    QUERY   = 3'd2,
    COMMIT  = 3'd3,
    TRANSIT = 3'd4
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: the output follows the input only after it has
// differed from the output for DEB_CYCLES consecutive samples.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_r;
  logic          level_r;

  // Count consecutive disagreeing samples; flip the level when the window fills
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (din == level_r) begin
      cnt_r <= '0;
    end else if (cnt_r == CW'(DEB_CYCLES - 1)) begin
      cnt_r   <= '0;
      level_r <= din;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign dout = level_r;

endmodule

// File: rtl/move_sequencer.sv
// Per-frame player movement: button sampling, collision query, commit and
// room transitions. Define MOVE_SEQ_DEBOUNCE_EN to debounce the buttons.
module move_sequencer
  import meikyuu_pkg::*;
#(
  parameter int STEP       = 2,
  parameter int SPRITE     = 16,
  parameter int DEB_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       coll_req,
  output logic [9:0] coll_x,
  output logic [9:0] coll_y,
  input  logic       coll_ack,
  input  logic       coll_hit,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic [1:0] room_x,
  output logic [1:0] room_y,
  output logic       busy,
  output logic       room_change
);

  // Package maxima assume the default sprite; shift them for other sizes
  localparam logic signed [10:0] STEP_C = 11'(STEP);
  localparam logic signed [10:0] XMIN_C = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_C = 11'(X_MAX + SPRITE_DEF - SPRITE);
  localparam logic signed [10:0] YMIN_C = 11'(Y_MIN);
  localparam logic signed [10:0] YMAX_C = 11'(Y_MAX + SPRITE_DEF - SPRITE);
  localparam logic [9:0] XMIN_P = 10'(X_MIN);
  localparam logic [9:0] XMAX_P = 10'(X_MAX + SPRITE_DEF - SPRITE);
  localparam logic [9:0] YMIN_P = 10'(Y_MIN);
  localparam logic [9:0] YMAX_P = 10'(Y_MAX + SPRITE_DEF - SPRITE);
  localparam logic [1:0] ROOM_LAST_X = 2'(GRID_W - 1);
  localparam logic [1:0] ROOM_LAST_Y = 2'(GRID_H - 1);

  state_e state_r, state_nxt_s;

  logic [3:0] sync1_r, sync2_r, btn_s;
  logic [9:0] x_pos_r, y_pos_r, coll_x_r, coll_y_r, tgt_x_r, tgt_y_r;
  logic [1:0] room_x_r, room_y_r, tgt_rx_r, tgt_ry_r;
  logic [7:0] timeout_r;
  logic       coll_req_r, busy_r, room_change_r;

  logic                axis_y_s, under_s, over_s, trans_s, no_move_s;
  logic signed [10:0]  delta_s, cur_s, min_s, max_s, cand_raw_s, cand_fix_s;
  logic [1:0]          room_s, last_s, room_nxt_s, tgt_rx_s, tgt_ry_s;
  logic [9:0]          cand_x_s, cand_y_s, tgt_x_s, tgt_y_s;

  // Two-flop synchronizer for the raw buttons, bit order {up, down, left, right}
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= {btn_up, btn_down, btn_left, btn_right};
      sync2_r <= sync1_r;
    end
  end

`ifdef MOVE_SEQ_DEBOUNCE_EN
  for (genvar i = 0; i < 4; i++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .din      (sync2_r[i]),
      .dout     (btn_s[i])
    );
  end
`else
  assign btn_s = sync2_r;
`endif

  // Direction decode, candidate arithmetic, clamping and transit target
  always_comb begin
    axis_y_s = 1'b0;
    delta_s  = STEP_C;
    if (btn_s[3]) begin
      axis_y_s = 1'b1;
      delta_s  = -STEP_C;
    end else if (btn_s[2]) begin
      axis_y_s = 1'b1;
      delta_s  = STEP_C;
    end else if (btn_s[1]) begin
      axis_y_s = 1'b0;
      delta_s  = -STEP_C;
    end else begin
      axis_y_s = 1'b0;
      delta_s  = STEP_C;
    end

    cur_s  = axis_y_s ? $signed({1'b0, y_pos_r}) : $signed({1'b0, x_pos_r});
    min_s  = axis_y_s ? YMIN_C : XMIN_C;
    max_s  = axis_y_s ? YMAX_C : XMAX_C;
    room_s = axis_y_s ? room_y_r : room_x_r;
    last_s = axis_y_s ? ROOM_LAST_Y : ROOM_LAST_X;

    cand_raw_s = cur_s + delta_s;
    under_s    = (cand_raw_s < min_s);
    over_s     = (cand_raw_s > max_s);
    if (under_s) begin
      cand_fix_s = min_s;
    end else if (over_s) begin
      cand_fix_s = max_s;
    end else begin
      cand_fix_s = cand_raw_s;
    end
    trans_s    = (under_s && (room_s != 2'd0)) || (over_s && (room_s != last_s));
    room_nxt_s = under_s ? (room_s - 2'd1) : (room_s + 2'd1);
    no_move_s  = (cand_fix_s == cur_s);

    cand_x_s = x_pos_r;
    cand_y_s = y_pos_r;
    tgt_x_s  = x_pos_r;
    tgt_y_s  = y_pos_r;
    tgt_rx_s = room_x_r;
    tgt_ry_s = room_y_r;
    if (axis_y_s) begin
      cand_y_s = cand_fix_s[9:0];
      tgt_y_s  = under_s ? YMAX_P : YMIN_P;
      tgt_ry_s = room_nxt_s;
    end else begin
      cand_x_s = cand_fix_s[9:0];
      tgt_x_s  = under_s ? XMAX_P : XMIN_P;
      tgt_rx_s = room_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_tick) state_nxt_s = SAMPLE;
        else            state_nxt_s = IDLE;
      end
      SAMPLE: begin
        if (btn_s == 4'd0)  state_nxt_s = IDLE;
        else if (trans_s)   state_nxt_s = TRANSIT;
        else if (no_move_s) state_nxt_s = IDLE;
        else                state_nxt_s = QUERY;
      end
      QUERY: begin
        if (coll_ack) begin
          if (coll_hit) state_nxt_s = IDLE;
          else          state_nxt_s = COMMIT;
        end else if (timeout_r == QUERY_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = QUERY;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      TRANSIT: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and position/query datapath
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      busy_r        <= 1'b0;
      room_change_r <= 1'b0;
      coll_req_r    <= 1'b0;
      coll_x_r      <= 10'd0;
      coll_y_r      <= 10'd0;
      timeout_r     <= 8'd0;
      x_pos_r       <= X_RST;
      y_pos_r       <= Y_RST;
      room_x_r      <= ROOM_RST;
      room_y_r      <= ROOM_RST;
      tgt_x_r       <= X_RST;
      tgt_y_r       <= Y_RST;
      tgt_rx_r      <= ROOM_RST;
      tgt_ry_r      <= ROOM_RST;
    end else begin
      state_r       <= state_nxt_s;
      busy_r        <= (state_nxt_s != IDLE);
      room_change_r <= 1'b0;
      case (state_r)
        SAMPLE: begin
          tgt_x_r  <= tgt_x_s;
          tgt_y_r  <= tgt_y_s;
          tgt_rx_r <= tgt_rx_s;
          tgt_ry_r <= tgt_ry_s;
          if (state_nxt_s == QUERY) begin
            coll_req_r <= 1'b1;
            coll_x_r   <= cand_x_s;
            coll_y_r   <= cand_y_s;
            timeout_r  <= 8'd0;
          end
        end
        QUERY: begin
          if (state_nxt_s != QUERY) begin
            coll_req_r <= 1'b0;
          end else begin
            timeout_r <= timeout_r + 8'd1;
          end
        end
        COMMIT: begin
          x_pos_r <= coll_x_r;
          y_pos_r <= coll_y_r;
        end
        TRANSIT: begin
          x_pos_r       <= tgt_x_r;
          y_pos_r       <= tgt_y_r;
          room_x_r      <= tgt_rx_r;
          room_y_r      <= tgt_ry_r;
          room_change_r <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign coll_req    = coll_req_r;
  assign coll_x      = coll_x_r;
  assign coll_y      = coll_y_r;
  assign x_pos       = x_pos_r;
  assign y_pos       = y_pos_r;
  assign room_x      = room_x_r;
  assign room_y      = room_y_r;
  assign busy        = busy_r;
  assign room_change = room_change_r;

endmodule

// File: tb/tb_move_sequencer.sv
// Randomised and directed bench for move_sequencer against a position/room
// reference model of the movement rules.
module tb_move_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       coll_ack = 1'b0, coll_hit = 1'b0;
  logic       coll_req, busy, room_change;
  logic [9:0] coll_x, coll_y, x_pos, y_pos;
  logic [1:0] room_x, room_y;

  int checks = 0;
  int errors = 0;
  int m_x, m_y, m_rx, m_ry;

  move_sequencer dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .coll_req    (coll_req),
    .coll_x      (coll_x),
    .coll_y      (coll_y),
    .coll_ack    (coll_ack),
    .coll_hit    (coll_hit),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .room_x      (room_x),
    .room_y      (room_y),
    .busy        (busy),
    .room_change (room_change)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 408; m_y = 234; m_rx = 1; m_ry = 1;
  endtask

  // kind: 0 = nothing happens, 1 = room transit, 2 = collision query
  task automatic predict(input logic [3:0] b, output int kind, output int nx,
                         output int ny, output int nrx, output int nry);
    int ax, d, c, lo, hi, r;
    nx = m_x; ny = m_y; nrx = m_rx; nry = m_ry; kind = 0;
    ax = 0; d = 0;
    if (b[3])      begin ax = 1; d = -2; end
    else if (b[2]) begin ax = 1; d = 2;  end
    else if (b[1]) begin ax = 0; d = -2; end
    else if (b[0]) begin ax = 0; d = 2;  end
    if (b != 4'd0) begin
      kind = 2;
      c  = (ax == 1 ? m_y : m_x) + d;
      lo = (ax == 1) ? 3 : 97;
      hi = (ax == 1) ? 466 : 720;
      r  = (ax == 1) ? m_ry : m_rx;
      if (c < lo) begin
        if (r > 0) begin kind = 1; r = r - 1; c = hi; end
        else c = lo;
      end else if (c > hi) begin
        if (r < 2) begin kind = 1; r = r + 1; c = lo; end
        else c = hi;
      end
      if (ax == 1) begin ny = c; nry = r; end
      else begin nx = c; nrx = r; end
      if (kind == 2 && nx == m_x && ny == m_y) kind = 0;
    end
  endtask

  // One frame: ack_dly = query cycles before ack (-1 = never); xtick adds a tick mid-query
  task automatic do_move(input logic [3:0] b, input int ack_dly, input logic hit,
                         input logic xtick);
    int kind, ex, ey, erx, ery;
    int n, req_n, req_cnt, rc_cnt, rc_n, upd_n, xy_bad, exp_req, exp_upd;
    logic done, committed;
    predict(b, kind, ex, ey, erx, ery);
    {btn_up, btn_down, btn_left, btn_right} = b;
    repeat (3) @(negedge CLOCK_50);
    check_eq("idle_before_tick", busy, 0);
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    n = 1; req_n = -1; req_cnt = 0; rc_cnt = 0; rc_n = -1; upd_n = -1; xy_bad = 0;
    done = 1'b0;
    check_eq("tick_accepted", busy, 1);
    while (!done && n < 400) begin
      coll_ack   = 1'b0;
      coll_hit   = 1'($urandom_range(0, 1));
      frame_tick = 1'b0;
      if (coll_req) begin
        req_cnt++;
        if (req_n < 0) req_n = n;
        if (coll_x != 10'(ex) || coll_y != 10'(ey)) xy_bad++;
        if (req_cnt == ack_dly + 1) begin coll_ack = 1'b1; coll_hit = hit; end
        if (xtick && req_cnt == 1) frame_tick = 1'b1;
      end
      if (room_change) begin
        rc_cnt++;
        if (rc_n < 0) rc_n = n;
      end
      if (upd_n < 0 && (x_pos != 10'(m_x) || y_pos != 10'(m_y) ||
                        room_x != 2'(m_rx) || room_y != 2'(m_ry))) upd_n = n;
      if (!busy) done = 1'b1;
      else begin
        @(negedge CLOCK_50);
        n++;
      end
    end
    coll_ack = 1'b0;
    frame_tick = 1'b0;
    check_eq("move_done", done, 1);
    committed = (kind == 2 && ack_dly >= 0 && !hit);
    exp_req = (kind == 2) ? ((ack_dly < 0) ? 255 : ack_dly + 1) : 0;
    check_eq("coll_req_cycles", req_cnt, exp_req);
    if (kind == 2) begin
      check_eq("coll_req_start", req_n, 2);
      check_eq("coll_xy_stable", xy_bad, 0);
    end
    check_eq("room_change_pulses", rc_cnt, (kind == 1) ? 1 : 0);
    if (kind == 1) check_eq("room_change_cycle", rc_n, 3);
    exp_upd = (kind == 1) ? 3 : (committed ? 4 + ack_dly : -1);
    check_eq("update_latency", upd_n, exp_upd);
    if (kind == 1 || committed) begin
      m_x = ex; m_y = ey; m_rx = erx; m_ry = ery;
    end
    check_eq("x_pos", x_pos, m_x);
    check_eq("y_pos", y_pos, m_y);
    check_eq("room_x", room_x, m_rx);
    check_eq("room_y", room_y, m_ry);
    @(negedge CLOCK_50);
    check_eq("idle_after", busy, 0);
  endtask

  task automatic reset_in_query();
    int waited;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0001;
    repeat (3) @(negedge CLOCK_50);
    frame_tick = 1'b1;
    @(negedge CLOCK_50);
    frame_tick = 1'b0;
    waited = 0;
    while (!coll_req && waited < 10) begin
      @(negedge CLOCK_50);
      waited++;
    end
    check_eq("rq_query_reached", coll_req, 1);
    @(negedge CLOCK_50);
    #3 reset = 1'b1;
    #1;
    check_eq("rq_req_async_drop", coll_req, 0);
    check_eq("rq_busy", busy, 0);
    check_eq("rq_x", x_pos, 408);
    check_eq("rq_y", y_pos, 234);
    @(negedge CLOCK_50);
    reset = 1'b0;
    coll_ack = 1'b1;
    coll_hit = 1'b0;
    @(negedge CLOCK_50);
    coll_ack = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_eq("rq_no_commit_x", x_pos, 408);
    check_eq("rq_no_commit_y", y_pos, 234);
    check_eq("rq_room", {room_x, room_y}, 4'b0101);
    check_eq("rq_idle", busy, 0);
    check_eq("rq_req_low", coll_req, 0);
    model_reset();
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [3:0] b;
    int d;
    logic h;
    repeat (3) @(negedge CLOCK_50);
    check_eq("rst_x", x_pos, 408);
    check_eq("rst_y", y_pos, 234);
    check_eq("rst_room_x", room_x, 1);
    check_eq("rst_room_y", room_y, 1);
    check_eq("rst_coll_req", coll_req, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_room_change", room_change, 0);
    check_eq("rst_coll_x", coll_x, 0);
    check_eq("rst_coll_y", coll_y, 0);
    reset = 1'b0;
    model_reset();

    do_move(4'b0001, 2, 1'b0, 1'b0);
    check_eq("right_commit_x", x_pos, 410);
    do_move(4'b1000, 2, 1'b1, 1'b0);
    check_eq("up_hit_y", y_pos, 234);
    do_move(4'b0001, -1, 1'b0, 1'b0);
    do_move(4'b0001, 1, 1'b0, 1'b0);
    do_move(4'b0100, 1, 1'b0, 1'b1);

    repeat (60) begin
      b = 4'($urandom_range(0, 15));
      d = $urandom_range(0, 6);
      h = ($urandom_range(0, 3) == 0);
      do_move(b, d, h, 1'b0);
    end

    reset_in_query();

    for (int i = 0; i < 400 && m_rx != 0; i++) do_move(4'b0010, 0, 1'b0, 1'b0);
    do_move(4'b0001, 0, 1'b0, 1'b0);
    check_eq("edge_entry_x", x_pos, 97);
    check_eq("edge_entry_room", room_x, 1);
    do_move(4'b0010, 0, 1'b0, 1'b0);
    check_eq("left_transit_x", x_pos, 720);
    check_eq("left_transit_room", room_x, 0);

    for (int i = 0; i < 400 && m_x != 97; i++) do_move(4'b0010, 0, 1'b0, 1'b0);
    do_move(4'b0010, 0, 1'b0, 1'b0);
    check_eq("left_wall_x", x_pos, 97);
    check_eq("left_wall_room", room_x, 0);

    for (int i = 0; i < 600 && !(m_ry == 0 && m_y == 3); i++) do_move(4'b1000, 0, 1'b0, 1'b0);
    do_move(4'b1000, 0, 1'b0, 1'b0);
    check_eq("top_wall_y", y_pos, 3);
    check_eq("top_wall_room", room_y, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 SHALL have parameter STEP, default 2, pixels moved per accepted frame.
REQ-002 SHALL have parameter SPRITE, default 16, player sprite edge in pixels.
REQ-003 SHALL have parameter DEB_CYCLES, default 500000, debounce stability window in CLOCK_50 cycles.
REQ-004 SHALL have port CLOCK_50  in  1  system clock.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick  in  1  one-cycle pulse per video frame.
REQ-007 SHALL have ports btn_up, btn_down, btn_left, btn_right  in  1 each  raw buttons, active-high, asynchronous.
REQ-008 SHALL have port coll_req  out  1  collision query request.
REQ-009 SHALL have ports coll_x, coll_y  out  10 each  candidate sprite top-left for the query.
REQ-010 SHALL have port coll_ack  in  1  query answered.
REQ-011 SHALL have port coll_hit  in  1  candidate collides; valid only while coll_ack=1.
REQ-012 SHALL have ports x_pos, y_pos  out  10 each  committed sprite top-left in VGA counter coordinates.
REQ-013 SHALL have ports room_x, room_y  out  2 each  current room in the 3x3 grid.
REQ-014 SHALL have port busy  out  1  high whenever FSM is not IDLE.
REQ-015 SHALL have port room_change  out  1  one-cycle pulse on room transition.

Function
REQ-016 SHALL use bounds X_MIN=97, X_MAX=736-SPRITE, Y_MIN=3, Y_MAX=482-SPRITE.
REQ-017 SHALL implement FSM states IDLE, SAMPLE, QUERY, COMMIT, TRANSIT.
REQ-018 IDLE -> SAMPLE on frame_tick; a frame_tick in any other state SHALL be ignored.
REQ-019 SAMPLE SHALL pick one direction by priority up > down > left > right; with no button pressed it SHALL return to IDLE.
REQ-020 Candidate SHALL be the committed position +/- STEP on one axis, computed in 11-bit signed arithmetic so that no wrap occurs below 0.
REQ-021 If the candidate lies beyond a bound and a neighbour room exists (index 0..2), SAMPLE SHALL go to TRANSIT without a query.
REQ-022 TRANSIT SHALL step the room index by one, place the sprite at the opposite bound on that axis, keep the other axis, and pulse room_change for exactly one cycle.
REQ-023 If the candidate lies beyond a bound and no neighbour exists, it SHALL be clamped to that bound; if the clamped value equals the current position, the FSM SHALL return to IDLE.
REQ-024 QUERY SHALL drive coll_req=1 with coll_x/coll_y stable until coll_ack=1 is sampled, then deassert coll_req on the next cycle.
REQ-025 coll_hit=0 SHALL commit the candidate in COMMIT; coll_hit=1 SHALL leave the position unchanged.
REQ-026 If coll_ack has not arrived within 255 cycles of entering QUERY, the query SHALL be treated as a hit and the FSM SHALL return to IDLE.
REQ-027 Latency from frame_tick to updated x_pos/y_pos SHALL be 3 cycles plus the ack wait; for a transition it SHALL be 2 cycles.
REQ-028 x_pos, y_pos, room_x and room_y SHALL change only in COMMIT or TRANSIT.

Reset
REQ-029 Reset SHALL force IDLE, x_pos=408, y_pos=234, room_x=1, room_y=1, coll_req=0, busy=0, room_change=0, coll_x=0, coll_y=0, and clear the timeout counter.
REQ-030 Reset asserted mid-query SHALL drop coll_req asynchronously, and no commit SHALL follow.

Configuration
REQ-031 With macro MOVE_SEQ_DEBOUNCE_EN defined, each button SHALL pass a 2-flop synchronizer and then a debouncer that changes state only after DEB_CYCLES consecutive stable samples.
REQ-032 Without MOVE_SEQ_DEBOUNCE_EN, each button SHALL pass the 2-flop synchronizer only, and DEB_CYCLES SHALL be unused.

Structure
REQ-033 Package meikyuu_pkg SHALL hold X_MIN, X_MAX, Y_MIN, Y_MAX, the reset position, GRID_W=3, GRID_H=3, and the FSM state enum.
REQ-034 The debouncer SHALL be sub-module btn_debounce, instantiated four times under MOVE_SEQ_DEBOUNCE_EN.

Verification
REQ-035 Reset, btn_right held, frame_tick, ack with hit=0 after 2 cycles -> coll_x=410, coll_y=234, and x_pos=410 after the commit.
REQ-036 btn_up held, ack with hit=1 -> y_pos stays 234 and coll_req is high for exactly 3 cycles.
REQ-037 x_pos=97, room_x=1, btn_left, frame_tick -> room_x=0, x_pos=720, one room_change pulse, coll_req never asserted.
REQ-038 x_pos=97, room_x=0, btn_left, frame_tick -> no change, FSM returns to IDLE, no query issued.
REQ-039 coll_ack never asserted -> coll_req drops after 255 cycles, position unchanged, and the next frame_tick is accepted.
REQ-040 Reset pulsed during QUERY, and a second frame_tick arriving during QUERY -> coll_req=0 with position at reset values, and the second tick is ignored.
